// File: rtl/mux4_pkg.sv
// Shared widths and select encodings for the 4:1 switch-to-LED selector.
package mux4_pkg;

    localparam int N_IN  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_IN0 = 2'd0;
    localparam sel_t SEL_IN1 = 2'd1;
    localparam sel_t SEL_IN2 = 2'd2;
    localparam sel_t SEL_IN3 = 2'd3;

endpackage

// File: rtl/mux4_sel_sync_chain.sv
// Parameterized-width flop-chain synchronizer with synchronous active-high reset.
// A depth of zero makes it a plain wire.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_bypass
            // Clock and reset are not needed when the chain collapses to a wire.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_q [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mux4_sel.sv
// 4:1 selector from board switches to one LED: synchronize all switches,
// pick one data bit by the synchronized select, register it onto led0.
module mux4_sel
    import mux4_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:4]      select,
    input  logic [N_IN-1:0] inputs,
    output logic            led0
);

    logic [SEL_W+N_IN-1:0] sync_bits;
    sel_t                  sel_s;
    logic [N_IN-1:0]       in_s;
    logic                  pick;

    // Select and data share one chain so every bit sees the same depth.
    sync_chain #(
        .WIDTH  (SEL_W + N_IN),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  ({select, inputs}),
        .dout (sync_bits)
    );

    assign sel_s = sync_bits[SEL_W+N_IN-1:N_IN];
    assign in_s  = sync_bits[N_IN-1:0];

    always_comb begin
        pick = 1'b0;
        case (sel_s)
            SEL_IN0: pick = in_s[0];
            SEL_IN1: pick = in_s[1];
            SEL_IN2: pick = in_s[2];
            SEL_IN3: pick = in_s[3];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led0 <= 1'b0;
        end else begin
            led0 <= pick;
        end
    end

endmodule

// File: tb/tb_mux4_sel.sv
// Bench for mux4_sel: default-depth and bypass instances share stimulus and are
// checked every cycle against per-instance expected-value queues.
module tb_mux4_sel;

    localparam int STG = 2;

    logic       clk;
    logic       rst;
    logic [5:4] select;
    logic [3:0] inputs;
    logic       led0;
    logic       led0_b;

    int checks;
    int passes;

    logic q_main [$];
    logic q_byp  [$];
    logic e;
    logic e0;

    mux4_sel #(.SYNC_STAGES(STG)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .select (select),
        .inputs (inputs),
        .led0   (led0)
    );

    mux4_sel #(.SYNC_STAGES(0)) u_dut_byp (
        .clk    (clk),
        .rst    (rst),
        .select (select),
        .inputs (inputs),
        .led0   (led0_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push the expected pick for the stimulus now on the pins, pop the value
    // due on this edge, then advance one clock and settle past the edge.
    task automatic tick(output logic exp_main, output logic exp_byp);
        logic [3:0] v;
        logic       p;
        v = inputs;
        p = v[select];
        if (rst) begin
            q_main.delete();
            for (int i = 0; i < STG; i++) q_main.push_back(1'b0);
            q_byp.delete();
            exp_main = 1'b0;
            exp_byp  = 1'b0;
        end else begin
            q_main.push_back(p);
            exp_main = q_main.pop_front();
            q_byp.push_back(p);
            exp_byp = q_byp.pop_front();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        inputs = 4'b1111;
        select = 2'b00;
        for (int c = 0; c < 3; c++) begin
            tick(e, e0);
            checks++;
            if (led0 !== 1'b0) $display("[TB] FAIL reset_hold led0 got %b want 0", led0);
            else passes++;
            checks++;
            if (led0_b !== 1'b0) $display("[TB] FAIL reset_hold_byp led0 got %b want 0", led0_b);
            else passes++;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(e, e0);
            checks++;
            if (led0 !== e) $display("[TB] FAIL reset_release led0 got %b want %b", led0, e);
            else passes++;
            checks++;
            if (led0_b !== e0) $display("[TB] FAIL reset_release_byp led0 got %b want %b", led0_b, e0);
            else passes++;
            if (c == 1) begin
                checks++;
                if (led0 !== 1'b0) $display("[TB] FAIL reset_edge2 led0 got %b want 0", led0);
                else passes++;
            end
            if (c == 2) begin
                checks++;
                if (led0 !== 1'b1) $display("[TB] FAIL reset_edge3 led0 got %b want 1", led0);
                else passes++;
            end
        end
    endtask

    task automatic test_select_walk();
        inputs = 4'b0000;
        for (int c = 0; c < 6; c++) tick(e, e0);
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            for (int c = 0; c < 16; c++) begin
                inputs    = 4'b0000;
                inputs[s] = (c < 10);
                tick(e, e0);
                checks++;
                if (led0 !== e) $display("[TB] FAIL walk_sel%0d led0 got %b want %b", s, led0, e);
                else passes++;
                checks++;
                if (led0_b !== e0) $display("[TB] FAIL walk_sel%0d_byp led0 got %b want %b", s, led0_b, e0);
                else passes++;
                if (c == 2 || c == 12) begin
                    checks++;
                    if (led0 !== (c == 2)) $display("[TB] FAIL walk_edge_sel%0d led0 got %b want %b", s, led0, (c == 2));
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_isolation();
        select = 2'b10;
        for (int c = 0; c < 10; c++) begin
            inputs = {c[0], 1'b0, ~c[0], c[0]};
            tick(e, e0);
            checks++;
            if (led0 !== e) $display("[TB] FAIL isolation led0 got %b want %b", led0, e);
            else passes++;
            if (c >= 3) begin
                checks++;
                if (led0 !== 1'b0) $display("[TB] FAIL isolation_zero led0 got %b want 0", led0);
                else passes++;
            end
        end
        inputs = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick(e, e0);
            checks++;
            if (led0 !== e) $display("[TB] FAIL isolation_set led0 got %b want %b", led0, e);
            else passes++;
            if (c == 2) begin
                checks++;
                if (led0 !== 1'b1) $display("[TB] FAIL isolation_edge3 led0 got %b want 1", led0);
                else passes++;
            end
        end
    endtask

    task automatic test_select_switch();
        inputs = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            for (int c = 0; c < 5; c++) begin
                tick(e, e0);
                checks++;
                if (led0 !== e) $display("[TB] FAIL switch_sel%0d led0 got %b want %b", s, led0, e);
                else passes++;
                checks++;
                if (led0_b !== e0) $display("[TB] FAIL switch_sel%0d_byp led0 got %b want %b", s, led0_b, e0);
                else passes++;
                if (c == 2) begin
                    checks++;
                    if (led0 !== ((s % 2) == 0)) $display("[TB] FAIL switch_edge_sel%0d led0 got %b want %b", s, led0, ((s % 2) == 0));
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        inputs = 4'b1000;
        select = 2'b11;
        for (int c = 0; c < 5; c++) tick(e, e0);
        checks++;
        if (led0 !== 1'b1) $display("[TB] FAIL midrun_pre led0 got %b want 1", led0);
        else passes++;
        rst = 1'b1;
        tick(e, e0);
        checks++;
        if (led0 !== 1'b0) $display("[TB] FAIL midrun_rst led0 got %b want 0", led0);
        else passes++;
        checks++;
        if (led0_b !== 1'b0) $display("[TB] FAIL midrun_rst_byp led0 got %b want 0", led0_b);
        else passes++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(e, e0);
            checks++;
            if (led0 !== e) $display("[TB] FAIL midrun_refill led0 got %b want %b", led0, e);
            else passes++;
            checks++;
            if (led0 !== (c >= 2)) $display("[TB] FAIL midrun_edge%0d led0 got %b want %b", c + 1, led0, (c >= 2));
            else passes++;
        end
    endtask

    task automatic test_bypass();
        rst    = 1'b1;
        inputs = 4'b0000;
        select = 2'b00;
        tick(e, e0);
        rst    = 1'b0;
        inputs = 4'b0010;
        select = 2'b01;
        tick(e, e0);
        checks++;
        if (led0_b !== 1'b1) $display("[TB] FAIL bypass_edge1 led0 got %b want 1", led0_b);
        else passes++;
        checks++;
        if (led0 !== e) $display("[TB] FAIL bypass_main led0 got %b want %b", led0, e);
        else passes++;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            inputs = 4'($urandom_range(0, 15));
            select = 2'($urandom_range(0, 3));
            tick(e, e0);
            checks++;
            if (led0 !== e) $display("[TB] FAIL random led0 got %b want %b", led0, e);
            else passes++;
            checks++;
            if (led0_b !== e0) $display("[TB] FAIL random_byp led0 got %b want %b", led0_b, e0);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        inputs = 4'b0000;
        select = 2'b00;
        #2;
        $display("[TB] starting mux4_sel bench");
        test_reset();
        test_select_walk();
        test_isolation();
        test_select_switch();
        test_midrun_reset();
        test_bypass();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
